exc_seq: RTL and testbench
==========================

EXC_SEQ -- requirements
Module: exc_seq

Interface
REQ-001 SHALL have clk, input, 1, system clock, rising-edge active.
REQ-002 SHALL have rst, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have exc_req, input, 1, exception request; level signal, held by the requester until exc_ack.
REQ-004 SHALL have exc_code, input, 5, ExcCode to record; 0 means interrupt.
REQ-005 SHALL have exc_pc, input, 32, PC of the faulting instruction; already adjusted for delay slot.
REQ-006 SHALL have exc_bd, input, 1, faulting instruction is in a delay slot.
REQ-007 SHALL have exc_badva_vld, input, 1, BadVAddr update required.
REQ-008 SHALL have exc_badva, input, 32, faulting address.
REQ-009 SHALL have eret_req, input, 1, ERET request; level signal, held until exc_ack.
REQ-010 SHALL have cp0_status, input, 32, current CP0 Status read value.
REQ-011 SHALL have cp0_cause, input, 32, current CP0 Cause read value.
REQ-012 SHALL have cp0_epc, input, 32, current CP0 EPC read value.
REQ-013 SHALL have cp0_wen, output, 1, CP0 write enable.
REQ-014 SHALL have cp0_waddr, output, 5, CP0 write address.
REQ-015 SHALL have cp0_wdata, output, 32, CP0 write data.
REQ-016 SHALL have busy, output, 1, sequencer active; the pipeline stalls while this is high.
REQ-017 SHALL have redirect_vld, output, 1, one-cycle PC redirect and pipeline flush strobe.
REQ-018 SHALL have redirect_pc, output, 32, redirect target.
REQ-019 SHALL have exc_ack, output, 1, one-cycle completion pulse, coincident with redirect_vld.

Function
REQ-020 SHALL implement a Moore FSM with states IDLE, W_BADVA, W_CAUSE, W_EPC, W_STATUS, E_STATUS and REDIRECT; all outputs SHALL decode from the state and the captured registers.
REQ-021 In IDLE, a rising clk edge with exc_req=1 SHALL capture exc_code, exc_pc, exc_bd, exc_badva, exc_badva_vld, cp0_status, cp0_cause and the flag kind=EXC.
  - Next state: W_BADVA if exc_badva_vld=1, else W_CAUSE.
REQ-022 In IDLE, eret_req=1 with exc_req=0 SHALL capture cp0_status and cp0_epc, set kind=ERET, and go to E_STATUS.
REQ-023 Simultaneous exc_req and eret_req SHALL serve the exception first; the ERET remains pending because requests are level.
REQ-024 Requests arriving in any state other than IDLE SHALL be ignored and not queued.
REQ-025 W_BADVA SHALL write: cp0_wen=1, waddr=8, wdata=captured badva. Next state: W_CAUSE.
REQ-026 W_CAUSE SHALL write waddr=13 with wdata = captured Cause, modified as follows:
  - bits 6:2 replaced by exc_code;
  - bit 31 replaced by exc_bd only when captured Status.EXL=0.
  - Next state: W_EPC if EXL=0, else W_STATUS.
REQ-027 W_EPC SHALL write waddr=14, wdata=captured exc_pc. Next state: W_STATUS.
REQ-028 W_STATUS SHALL write waddr=12, wdata = captured Status with bit 1 set. Next state: REDIRECT.
REQ-029 E_STATUS SHALL write waddr=12, wdata = captured Status with bit 1 cleared. Next state: REDIRECT.
REQ-030 REDIRECT SHALL assert redirect_vld=1 and exc_ack=1 for exactly one cycle, then return to IDLE.
REQ-031 redirect_pc for kind=EXC SHALL be 0xBFC00380 when captured Status.BEV (bit 22)=1, else 0x80000180.
REQ-032 redirect_pc for kind=ERET SHALL be the captured EPC.
REQ-033 busy SHALL be 1 in every state except IDLE; cp0_wen SHALL be 0 in IDLE and REDIRECT.
REQ-034 Latency from the accepting edge to redirect_vld, counted in cycles:
  - 5 for EXC with BadVAddr and EXL=0;
  - 4 for EXC without BadVAddr and EXL=0;
  - one less than the above when EXL=1;
  - 2 for ERET.
REQ-035 Captured values SHALL be used for the whole sequence; input changes after acceptance SHALL have no effect.

Reset
REQ-036 rst=1 SHALL immediately force IDLE, clear all captured registers, and drive all outputs to 0, including mid-sequence.
REQ-037 A sequence interrupted by reset SHALL NOT resume; the requester re-requests after reset.

Structure
REQ-038 The CP0 address constants (BadVAddr=8, Status=12, Cause=13, EPC=14) and the two exception vector constants SHALL live in the shared Defines package.
REQ-039 FSM state encodings SHALL be local to exc_seq.
REQ-040 exc_seq SHALL be a single module with no sub-modules.

Verification
REQ-041 exc_req with code=4, badva_vld=1, badva=0x00001233, pc=0x80000100, bd=0, Status=0x00400000 -> required response:
  - writes (8, 0x00001233), (13, code 4 in 6:2), (14, 0x80000100), (12, 0x00400002) on consecutive cycles;
  - redirect_pc=0xBFC00380 on cycle 5.
REQ-042 Interrupt with code=0, bd=1, pc=0x80000200, Status=0x00000001 -> required response:
  - no BadVAddr write;
  - Cause bit 31=1; EPC=0x80000200;
  - redirect_pc=0x80000180 on cycle 4.
REQ-043 exc_req with Status=0x00000003 (EXL=1) -> required response:
  - no EPC write;
  - Cause bit 31 unchanged;
  - redirect on cycle 3.
REQ-044 exc_req and eret_req both high, EPC=0x80001000 -> required response:
  - exception completes first;
  - then the ERET writes Status with bit 1=0;
  - redirect_pc=0x80001000 two cycles after ERET acceptance.
REQ-045 rst pulsed during W_EPC -> required response:
  - busy, cp0_wen and redirect_vld are 0 immediately;
  - after reset, a new request completes normally.

Source files
------------

// File: rtl/exc_seq_pkg.sv
// Shared CP0 defines for the exception sequencer: register addresses, vectors,
// Status bit positions and the Cause update helper.
package exc_seq_pkg;

  localparam logic [4:0]  CP0_BADVADDR = 5'd8;
  localparam logic [4:0]  CP0_STATUS   = 5'd12;
  localparam logic [4:0]  CP0_CAUSE    = 5'd13;
  localparam logic [4:0]  CP0_EPC      = 5'd14;

  localparam logic [31:0] VEC_BOOT     = 32'hBFC0_0380;
  localparam logic [31:0] VEC_NORMAL   = 32'h8000_0180;

  localparam int STATUS_EXL = 1;
  localparam int STATUS_BEV = 22;

  typedef enum logic {KIND_EXC, KIND_ERET} kind_e;

  // BD is only recorded for a first-level exception; nested ones keep the old BD.
  function automatic logic [31:0] cause_update(input logic [31:0] cause,
                                               input logic [4:0]  code,
                                               input logic        bd,
                                               input logic        exl);
    logic [31:0] c;
    c      = cause;
    c[6:2] = code;
    if (!exl) c[31] = bd;
    return c;
  endfunction

  function automatic logic [31:0] exc_vector(input logic bev);
    return bev ? VEC_BOOT : VEC_NORMAL;
  endfunction

endpackage

// File: rtl/exc_seq_if.sv
// Request / CP0 write / redirect bundle between the pipeline and the exception sequencer.
interface exc_seq_if;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        exc_badva_vld;
  logic [31:0] exc_badva;
  logic        eret_req;
  logic [31:0] cp0_status;
  logic [31:0] cp0_cause;
  logic [31:0] cp0_epc;
  logic        cp0_wen;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic        busy;
  logic        redirect_vld;
  logic [31:0] redirect_pc;
  logic        exc_ack;

  modport master (
    output exc_req, exc_code, exc_pc, exc_bd, exc_badva_vld, exc_badva, eret_req,
           cp0_status, cp0_cause, cp0_epc,
    input  cp0_wen, cp0_waddr, cp0_wdata, busy, redirect_vld, redirect_pc, exc_ack
  );

  modport slave (
    input  exc_req, exc_code, exc_pc, exc_bd, exc_badva_vld, exc_badva, eret_req,
           cp0_status, cp0_cause, cp0_epc,
    output cp0_wen, cp0_waddr, cp0_wdata, busy, redirect_vld, redirect_pc, exc_ack
  );
endinterface

// File: rtl/exc_seq.sv
// Exception entry / ERET sequencer: snapshots the request, walks the CP0 writes one
// per cycle, then issues a single redirect+ack strobe.
//
// state    | meaning
// IDLE     | waiting for exc_req / eret_req
// W_BADVA  | writing BadVAddr
// W_CAUSE  | writing Cause (ExcCode, BD)
// W_EPC    | writing EPC (first-level exceptions only)
// W_STATUS | writing Status with EXL set
// E_STATUS | ERET: writing Status with EXL cleared
// REDIRECT | redirect_vld + exc_ack for one cycle
module exc_seq
  import exc_seq_pkg::*;
(
  input logic     clk,
  input logic     rst,
  exc_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_W_BADVA, S_W_CAUSE, S_W_EPC, S_W_STATUS, S_E_STATUS, S_REDIRECT
  } state_e;

  state_e      state_q;
  kind_e       kind_q;
  logic [4:0]  code_q;
  logic [31:0] pc_q;
  logic        bd_q;
  logic [31:0] status_q;
  logic [31:0] cause_q;
  logic [31:0] epc_q;

  logic        busy_q;
  logic        wen_q;
  logic [4:0]  waddr_q;
  logic [31:0] wdata_q;
  logic        redir_vld_q;
  logic [31:0] redir_pc_q;

  // Outputs are registered alongside the state, so each branch loads the
  // outputs that belong to the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      kind_q      <= KIND_EXC;
      code_q      <= '0;
      pc_q        <= '0;
      bd_q        <= 1'b0;
      status_q    <= '0;
      cause_q     <= '0;
      epc_q       <= '0;
      busy_q      <= 1'b0;
      wen_q       <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      redir_vld_q <= 1'b0;
      redir_pc_q  <= '0;
    end else begin
      busy_q      <= 1'b1;
      wen_q       <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      redir_vld_q <= 1'b0;
      redir_pc_q  <= '0;
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (bus.exc_req) begin
            kind_q   <= KIND_EXC;
            code_q   <= bus.exc_code;
            pc_q     <= bus.exc_pc;
            bd_q     <= bus.exc_bd;
            status_q <= bus.cp0_status;
            cause_q  <= bus.cp0_cause;
            busy_q   <= 1'b1;
            wen_q    <= 1'b1;
            if (bus.exc_badva_vld) begin
              state_q <= S_W_BADVA;
              waddr_q <= CP0_BADVADDR;
              wdata_q <= bus.exc_badva;
            end else begin
              state_q <= S_W_CAUSE;
              waddr_q <= CP0_CAUSE;
              wdata_q <= cause_update(bus.cp0_cause, bus.exc_code, bus.exc_bd,
                                      bus.cp0_status[STATUS_EXL]);
            end
          end else if (bus.eret_req) begin
            kind_q   <= KIND_ERET;
            status_q <= bus.cp0_status;
            epc_q    <= bus.cp0_epc;
            state_q  <= S_E_STATUS;
            busy_q   <= 1'b1;
            wen_q    <= 1'b1;
            waddr_q  <= CP0_STATUS;
            wdata_q  <= bus.cp0_status & ~(32'd1 << STATUS_EXL);
          end
        end
        S_W_BADVA: begin
          state_q <= S_W_CAUSE;
          wen_q   <= 1'b1;
          waddr_q <= CP0_CAUSE;
          wdata_q <= cause_update(cause_q, code_q, bd_q, status_q[STATUS_EXL]);
        end
        S_W_CAUSE: begin
          wen_q <= 1'b1;
          if (!status_q[STATUS_EXL]) begin
            state_q <= S_W_EPC;
            waddr_q <= CP0_EPC;
            wdata_q <= pc_q;
          end else begin
            state_q <= S_W_STATUS;
            waddr_q <= CP0_STATUS;
            wdata_q <= status_q | (32'd1 << STATUS_EXL);
          end
        end
        S_W_EPC: begin
          state_q <= S_W_STATUS;
          wen_q   <= 1'b1;
          waddr_q <= CP0_STATUS;
          wdata_q <= status_q | (32'd1 << STATUS_EXL);
        end
        S_W_STATUS, S_E_STATUS: begin
          state_q     <= S_REDIRECT;
          redir_vld_q <= 1'b1;
          redir_pc_q  <= (kind_q == KIND_ERET) ? epc_q : exc_vector(status_q[STATUS_BEV]);
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.cp0_wen      = wen_q;
  assign bus.cp0_waddr    = waddr_q;
  assign bus.cp0_wdata    = wdata_q;
  assign bus.redirect_vld = redir_vld_q;
  assign bus.redirect_pc  = redir_pc_q;
  assign bus.exc_ack      = redir_vld_q;

endmodule

// File: tb/tb_exc_seq.sv
// Directed bench for exc_seq: per-cycle CP0 write / redirect sequences checked
// against hand-computed tables.
module tb_exc_seq;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  exc_seq_if bus();

  exc_seq dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        s_busy[1:12];
  logic        s_wen [1:12];
  logic [4:0]  s_addr[1:12];
  logic [31:0] s_data[1:12];
  logic        s_rv  [1:12];
  logic        s_ack [1:12];
  logic [31:0] s_rpc [1:12];

  logic        e_busy[1:12];
  logic        e_wen [1:12];
  logic [4:0]  e_addr[1:12];
  logic [31:0] e_data[1:12];
  logic        e_rv  [1:12];
  logic [31:0] e_rpc [1:12];

  task automatic clear_exp();
    for (int k = 1; k <= 12; k++) begin
      e_busy[k] = 1'b0; e_wen[k] = 1'b0; e_addr[k] = '0;
      e_data[k] = '0;   e_rv[k]  = 1'b0; e_rpc[k]  = '0;
    end
  endtask

  task automatic set_exp(input int k, input logic busy, input logic wen, input logic [4:0] a,
                         input logic [31:0] d, input logic rv, input logic [31:0] rpc);
    e_busy[k] = busy; e_wen[k] = wen; e_addr[k] = a;
    e_data[k] = d;    e_rv[k]  = rv;  e_rpc[k]  = rpc;
  endtask

  // Samples each cycle at the falling edge; the requester drops its level on ack.
  task automatic capture(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      @(negedge clk);
      s_busy[k] = bus.busy;   s_wen[k] = bus.cp0_wen;      s_addr[k] = bus.cp0_waddr;
      s_data[k] = bus.cp0_wdata; s_rv[k] = bus.redirect_vld;
      s_ack[k]  = bus.exc_ack; s_rpc[k] = bus.redirect_pc;
      if (bus.exc_ack) begin
        if (bus.exc_req) bus.exc_req = 1'b0;
        else             bus.eret_req = 1'b0;
      end
    end
  endtask

  task automatic scramble_exc();
    bus.exc_code      = 5'h1f;
    bus.exc_pc        = 32'hDEAD_BEEF;
    bus.exc_bd        = ~bus.exc_bd;
    bus.exc_badva     = 32'h0BAD_0BAD;
    bus.exc_badva_vld = ~bus.exc_badva_vld;
    bus.cp0_status    = 32'hFFFF_FFFF;
    bus.cp0_cause     = 32'h5555_5555;
  endtask

  task automatic drive_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                           input logic bv, input logic [31:0] badva,
                           input logic [31:0] status, input logic [31:0] cause);
    bus.exc_code = code; bus.exc_pc = pc; bus.exc_bd = bd;
    bus.exc_badva_vld = bv; bus.exc_badva = badva;
    bus.cp0_status = status; bus.cp0_cause = cause;
    bus.exc_req = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if ({bus.busy, bus.cp0_wen, bus.redirect_vld, bus.exc_ack} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000",
               {bus.busy, bus.cp0_wen, bus.redirect_vld, bus.exc_ack});
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if ({bus.cp0_waddr, bus.cp0_wdata, bus.redirect_pc} !== 69'd0) begin
      failures++;
      $display("FAIL reset_data got waddr=%0h wdata=%h rpc=%h exp=0",
               bus.cp0_waddr, bus.cp0_wdata, bus.redirect_pc);
    end
    rst = 1'b0;
  endtask

  task automatic test_exc_badva();
    clear_exp();
    set_exp(1, 1, 1, 5'd8,  32'h0000_1233, 0, '0);
    set_exp(2, 1, 1, 5'd13, 32'h0000_8010, 0, '0);
    set_exp(3, 1, 1, 5'd14, 32'h8000_0100, 0, '0);
    set_exp(4, 1, 1, 5'd12, 32'h0040_0002, 0, '0);
    set_exp(5, 1, 0, 5'd0,  '0,            1, 32'hBFC0_0380);
    drive_exc(5'd4, 32'h8000_0100, 1'b0, 1'b1, 32'h0000_1233, 32'h0040_0000, 32'h0000_8000);
    @(posedge clk); #1 scramble_exc();
    capture(1, 6);
    for (int k = 1; k <= 6; k++) begin
      checks++;
      if (s_busy[k] !== e_busy[k]) begin failures++;
        $display("FAIL badva_busy c%0d got=%0b exp=%0b", k, s_busy[k], e_busy[k]); end
      checks++;
      if (s_wen[k] !== e_wen[k]) begin failures++;
        $display("FAIL badva_wen c%0d got=%0b exp=%0b", k, s_wen[k], e_wen[k]); end
      if (e_wen[k]) begin
        checks++;
        if ({s_addr[k], s_data[k]} !== {e_addr[k], e_data[k]}) begin failures++;
          $display("FAIL badva_write c%0d got=(%0d,%h) exp=(%0d,%h)", k, s_addr[k], s_data[k], e_addr[k], e_data[k]); end
      end
      checks++;
      if ({s_rv[k], s_ack[k]} !== {e_rv[k], e_rv[k]}) begin failures++;
        $display("FAIL badva_redir c%0d got rv/ack=%b%b exp=%b", k, s_rv[k], s_ack[k], e_rv[k]); end
      if (e_rv[k]) begin
        checks++;
        if (s_rpc[k] !== e_rpc[k]) begin failures++;
          $display("FAIL badva_rpc c%0d got=%h exp=%h", k, s_rpc[k], e_rpc[k]); end
      end
    end
  endtask

  task automatic test_interrupt();
    clear_exp();
    set_exp(1, 1, 1, 5'd13, 32'h8000_0400, 0, '0);
    set_exp(2, 1, 1, 5'd14, 32'h8000_0200, 0, '0);
    set_exp(3, 1, 1, 5'd12, 32'h0000_0003, 0, '0);
    set_exp(4, 1, 0, 5'd0,  '0,            1, 32'h8000_0180);
    drive_exc(5'd0, 32'h8000_0200, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0001, 32'h0000_0400);
    @(posedge clk); #1 scramble_exc();
    capture(1, 5);
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (s_busy[k] !== e_busy[k]) begin failures++;
        $display("FAIL int_busy c%0d got=%0b exp=%0b", k, s_busy[k], e_busy[k]); end
      checks++;
      if (s_wen[k] !== e_wen[k]) begin failures++;
        $display("FAIL int_wen c%0d got=%0b exp=%0b", k, s_wen[k], e_wen[k]); end
      if (e_wen[k]) begin
        checks++;
        if ({s_addr[k], s_data[k]} !== {e_addr[k], e_data[k]}) begin failures++;
          $display("FAIL int_write c%0d got=(%0d,%h) exp=(%0d,%h)", k, s_addr[k], s_data[k], e_addr[k], e_data[k]); end
      end
      checks++;
      if ({s_rv[k], s_ack[k]} !== {e_rv[k], e_rv[k]}) begin failures++;
        $display("FAIL int_redir c%0d got rv/ack=%b%b exp=%b", k, s_rv[k], s_ack[k], e_rv[k]); end
      if (e_rv[k]) begin
        checks++;
        if (s_rpc[k] !== e_rpc[k]) begin failures++;
          $display("FAIL int_rpc c%0d got=%h exp=%h", k, s_rpc[k], e_rpc[k]); end
      end
    end
  endtask

  // EXL=1: no EPC write, Cause BD untouched; an ERET pulse mid-sequence is dropped.
  task automatic test_exl();
    clear_exp();
    set_exp(1, 1, 1, 5'd13, 32'h8000_0020, 0, '0);
    set_exp(2, 1, 1, 5'd12, 32'h0000_0003, 0, '0);
    set_exp(3, 1, 0, 5'd0,  '0,            1, 32'h8000_0180);
    drive_exc(5'd8, 32'h8000_0400, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0003, 32'h8000_0000);
    bus.cp0_epc = 32'h8000_0F00;
    @(posedge clk); #1 scramble_exc();
    capture(1, 1);
    bus.eret_req = 1'b1;
    capture(2, 2);
    bus.eret_req = 1'b0;
    capture(3, 5);
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (s_busy[k] !== e_busy[k]) begin failures++;
        $display("FAIL exl_busy c%0d got=%0b exp=%0b", k, s_busy[k], e_busy[k]); end
      checks++;
      if (s_wen[k] !== e_wen[k]) begin failures++;
        $display("FAIL exl_wen c%0d got=%0b exp=%0b", k, s_wen[k], e_wen[k]); end
      if (e_wen[k]) begin
        checks++;
        if ({s_addr[k], s_data[k]} !== {e_addr[k], e_data[k]}) begin failures++;
          $display("FAIL exl_write c%0d got=(%0d,%h) exp=(%0d,%h)", k, s_addr[k], s_data[k], e_addr[k], e_data[k]); end
      end
      checks++;
      if ({s_rv[k], s_ack[k]} !== {e_rv[k], e_rv[k]}) begin failures++;
        $display("FAIL exl_redir c%0d got rv/ack=%b%b exp=%b", k, s_rv[k], s_ack[k], e_rv[k]); end
      if (e_rv[k]) begin
        checks++;
        if (s_rpc[k] !== e_rpc[k]) begin failures++;
          $display("FAIL exl_rpc c%0d got=%h exp=%h", k, s_rpc[k], e_rpc[k]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_exp();
    set_exp(1, 1, 1, 5'd13, 32'h0000_0030, 0, '0);
    set_exp(2, 1, 1, 5'd14, 32'h8000_0300, 0, '0);
    set_exp(3, 1, 1, 5'd12, 32'h0000_0012, 0, '0);
    set_exp(4, 1, 0, 5'd0,  '0,            1, 32'h8000_0180);
    set_exp(6, 1, 1, 5'd12, 32'h0000_0010, 0, '0);
    set_exp(7, 1, 0, 5'd0,  '0,            1, 32'h8000_1000);
    drive_exc(5'd12, 32'h8000_0300, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0010, 32'h0000_0000);
    bus.cp0_epc  = 32'h8000_1000;
    bus.eret_req = 1'b1;
    @(posedge clk); #1 scramble_exc();
    capture(1, 4);
    bus.cp0_status = 32'h0000_0012;
    capture(5, 8);
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (s_busy[k] !== e_busy[k]) begin failures++;
        $display("FAIL b2b_busy c%0d got=%0b exp=%0b", k, s_busy[k], e_busy[k]); end
      checks++;
      if (s_wen[k] !== e_wen[k]) begin failures++;
        $display("FAIL b2b_wen c%0d got=%0b exp=%0b", k, s_wen[k], e_wen[k]); end
      if (e_wen[k]) begin
        checks++;
        if ({s_addr[k], s_data[k]} !== {e_addr[k], e_data[k]}) begin failures++;
          $display("FAIL b2b_write c%0d got=(%0d,%h) exp=(%0d,%h)", k, s_addr[k], s_data[k], e_addr[k], e_data[k]); end
      end
      checks++;
      if ({s_rv[k], s_ack[k]} !== {e_rv[k], e_rv[k]}) begin failures++;
        $display("FAIL b2b_redir c%0d got rv/ack=%b%b exp=%b", k, s_rv[k], s_ack[k], e_rv[k]); end
      if (e_rv[k]) begin
        checks++;
        if (s_rpc[k] !== e_rpc[k]) begin failures++;
          $display("FAIL b2b_rpc c%0d got=%h exp=%h", k, s_rpc[k], e_rpc[k]); end
      end
    end
  endtask

  task automatic test_eret();
    clear_exp();
    set_exp(1, 1, 1, 5'd12, 32'h0040_0011, 0, '0);
    set_exp(2, 1, 0, 5'd0,  '0,            1, 32'h8000_2000);
    bus.cp0_status = 32'h0040_0013;
    bus.cp0_epc    = 32'h8000_2000;
    bus.eret_req   = 1'b1;
    @(posedge clk); #1;
    bus.cp0_status = 32'h0000_0000;
    bus.cp0_epc    = 32'hDEAD_BEEF;
    capture(1, 3);
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if ({s_busy[k], s_wen[k]} !== {e_busy[k], e_wen[k]}) begin failures++;
        $display("FAIL eret_ctrl c%0d got busy/wen=%b%b exp=%b%b", k, s_busy[k], s_wen[k], e_busy[k], e_wen[k]); end
      if (e_wen[k]) begin
        checks++;
        if ({s_addr[k], s_data[k]} !== {e_addr[k], e_data[k]}) begin failures++;
          $display("FAIL eret_write c%0d got=(%0d,%h) exp=(%0d,%h)", k, s_addr[k], s_data[k], e_addr[k], e_data[k]); end
      end
      checks++;
      if ({s_rv[k], s_ack[k]} !== {e_rv[k], e_rv[k]}) begin failures++;
        $display("FAIL eret_redir c%0d got rv/ack=%b%b exp=%b", k, s_rv[k], s_ack[k], e_rv[k]); end
      if (e_rv[k]) begin
        checks++;
        if (s_rpc[k] !== e_rpc[k]) begin failures++;
          $display("FAIL eret_rpc c%0d got=%h exp=%h", k, s_rpc[k], e_rpc[k]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive_exc(5'd4, 32'h8000_0100, 1'b0, 1'b1, 32'h0000_1233, 32'h0040_0000, 32'h0000_0000);
    @(posedge clk); #1 scramble_exc();
    capture(1, 3);
    checks++;
    if ({s_wen[3], s_addr[3]} !== {1'b1, 5'd14}) begin failures++;
      $display("FAIL rstmid_epc got wen/addr=%b/%0d exp=1/14", s_wen[3], s_addr[3]); end
    #2 rst = 1'b1;
    bus.exc_req = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.cp0_wen, bus.redirect_vld, bus.exc_ack} !== 4'b0000) begin failures++;
      $display("FAIL rstmid_outs got=%b exp=0000",
               {bus.busy, bus.cp0_wen, bus.redirect_vld, bus.exc_ack}); end
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    capture(1, 2);
    checks++;
    if ({s_busy[2], s_wen[2], s_rv[2]} !== 3'b000) begin failures++;
      $display("FAIL rstmid_resume got busy/wen/rv=%b%b%b exp=000", s_busy[2], s_wen[2], s_rv[2]); end
    test_interrupt();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    bus.exc_req = 1'b0; bus.eret_req = 1'b0;
    bus.exc_code = '0; bus.exc_pc = '0; bus.exc_bd = 1'b0;
    bus.exc_badva_vld = 1'b0; bus.exc_badva = '0;
    bus.cp0_status = '0; bus.cp0_cause = '0; bus.cp0_epc = '0;
    test_reset();
    test_exc_badva();
    test_interrupt();
    test_exl();
    test_back_to_back();
    test_eret();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
